product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator_pkg.sv | 14 +
 rtl/product_accumulator.sv | 108 ++++++++++
 tb/tb_product_accumulator.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for product_accumulator.
// Holds the default width constants and the two-state FSM encoding.
package product_accumulator_pkg;

  localparam int unsigned DEF_PARALLELISM = 8;
  localparam int unsigned DEF_GUARD_BITS  = 8;
  localparam int unsigned DEF_CNT_WIDTH   = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/product_accumulator.sv
// product_accumulator: sums a sequence of unsigned products from an upstream
// multiplier, then holds the sum until the consumer takes it.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : product beat present
//   in_ready   : beat accepted this cycle (decoded from state)
//   product    : 2*PARALLELISM-bit unsigned product
//   in_last    : final beat of the sequence, qualified by in_valid
//   out_valid  : result held and valid (decoded from state)
//   out_ready  : consumer accepts the result
//   acc_out    : sum of the sequence, mod 2^ACC_WIDTH
//   beat_count : beats in the sequence, saturating
//   overflow   : sticky carry out of the accumulator during the sequence
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int unsigned PARALLELISM = DEF_PARALLELISM,
  parameter int unsigned GUARD_BITS  = DEF_GUARD_BITS,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [2*PARALLELISM-1:0]             product,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [2*PARALLELISM+GUARD_BITS-1:0]  acc_out,
  output logic [CNT_WIDTH-1:0]                 beat_count,
  output logic                                 overflow
);

  localparam int unsigned ACC_WIDTH = 2*PARALLELISM + GUARD_BITS;
  localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;

  acc_state_e r_state;
  acc_state_e w_state_nxt;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;

  logic                 w_accept;
  logic                 w_drain;
  logic [SUM_WIDTH-1:0] w_sum;
  logic                 w_cnt_sat;

  assign w_accept  = in_valid && (r_state == ST_ACCUM);
  assign w_drain   = out_ready && (r_state == ST_HOLD);
  // Extra top bit captures the carry out of the accumulator.
  assign w_sum     = SUM_WIDTH'(r_acc) + SUM_WIDTH'(product);
  assign w_cnt_sat = (r_cnt == {CNT_WIDTH{1'b1}});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: if (w_accept && in_last) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready)           w_state_nxt = ST_ACCUM;
      default:                           w_state_nxt = ST_ACCUM;
    endcase
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: in_ready  = 1'b1;
      ST_HOLD:  out_valid = 1'b1;
      default:  in_ready  = 1'b0;
    endcase
  end

  // Accumulator datapath; frozen in HOLD until the result drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_drain) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum[ACC_WIDTH-1:0];
      if (!w_cnt_sat) r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_sum[ACC_WIDTH]) r_ovf <= 1'b1;
    end
  end

  assign acc_out    = r_acc;
  assign beat_count = r_cnt;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three parameterisations share one stimulus
// stream and are each compared every cycle against a sequence-level model
// (true integer sum, beat count, holding flag).
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_last, out_ready;
  logic [15:0] product;

  logic        rdy [3];
  logic        vld [3];
  logic        ovf [3];
  logic [23:0] acc0;
  logic [15:0] acc1;
  logic [23:0] acc2;
  logic [7:0]  cnt0, cnt1;
  logic [1:0]  cnt2;

  product_accumulator #(.PARALLELISM(8), .GUARD_BITS(8), .CNT_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .product(product),
    .in_last(in_last), .out_valid(vld[0]), .out_ready(out_ready), .acc_out(acc0),
    .beat_count(cnt0), .overflow(ovf[0]));

  product_accumulator #(.PARALLELISM(8), .GUARD_BITS(0), .CNT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .product(product),
    .in_last(in_last), .out_valid(vld[1]), .out_ready(out_ready), .acc_out(acc1),
    .beat_count(cnt1), .overflow(ovf[1]));

  product_accumulator #(.PARALLELISM(8), .GUARD_BITS(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .product(product),
    .in_last(in_last), .out_valid(vld[2]), .out_ready(out_ready), .acc_out(acc2),
    .beat_count(cnt2), .overflow(ovf[2]));

  int checks   = 0;
  int failures = 0;

  // Sequence-level reference: unbounded sum and beat count per instance.
  int unsigned     aw [3] = '{24, 16, 24};
  int unsigned     cw [3] = '{8, 8, 2};
  longint unsigned m_sum [3];
  int              m_n   [3];
  bit              m_hold[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] get_acc(int k);
    case (k)
      0:       return 64'(acc0);
      1:       return 64'(acc1);
      default: return 64'(acc2);
    endcase
  endfunction

  function automatic logic [63:0] get_cnt(int k);
    case (k)
      0:       return 64'(cnt0);
      1:       return 64'(cnt1);
      default: return 64'(cnt2);
    endcase
  endfunction

  function automatic logic [63:0] exp_acc(int k);
    return 64'(m_sum[k] % (64'd1 << aw[k]));
  endfunction

  function automatic logic [63:0] exp_cnt(int k);
    longint unsigned mx;
    mx = (64'd1 << cw[k]) - 1;
    return (longint'(m_n[k]) > longint'(mx)) ? mx : 64'(m_n[k]);
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d acc_out", k),    get_acc(k), exp_acc(k));
      chk($sformatf("dut%0d beat_count", k), get_cnt(k), exp_cnt(k));
      chk($sformatf("dut%0d overflow", k),   64'(ovf[k]), 64'(m_sum[k] >= (64'd1 << aw[k])));
      chk($sformatf("dut%0d in_ready", k),   64'(rdy[k]), 64'(!m_hold[k]));
      chk($sformatf("dut%0d out_valid", k),  64'(vld[k]), 64'(m_hold[k]));
    end
  endtask

  // One clock: update the model from the inputs in effect, then compare #1 after the edge.
  task automatic cycle();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_sum[k] = 0; m_n[k] = 0; m_hold[k] = 0;
      end else if (m_hold[k]) begin
        if (out_ready) begin
          m_sum[k] = 0; m_n[k] = 0; m_hold[k] = 0;
        end
      end else if (in_valid) begin
        m_sum[k] += 64'(product);
        m_n[k]++;
        if (in_last) m_hold[k] = 1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic beat(input logic [15:0] p, input logic last);
    in_valid = 1'b1; product = p; in_last = last;
    cycle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
  endtask

  typedef struct {
    int          n;
    logic [15:0] p [4];
    logic [63:0] e_acc;
    logic [63:0] e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t tbl [4];

  initial begin
    for (int k = 0; k < 3; k++) begin m_sum[k] = 0; m_n[k] = 0; m_hold[k] = 0; end
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; product = '0;

    tbl[0] = '{n: 3, p: '{16'd10, 16'd20, 16'd30, 16'd0},             e_acc: 64'd60,      e_cnt: 64'd3, e_ovf: 1'b0};
    tbl[1] = '{n: 1, p: '{16'h00FF, 16'd0, 16'd0, 16'd0},             e_acc: 64'h00FF,    e_cnt: 64'd1, e_ovf: 1'b0};
    tbl[2] = '{n: 2, p: '{16'd0, 16'd0, 16'd0, 16'd0},                e_acc: 64'd0,       e_cnt: 64'd2, e_ovf: 1'b0};
    tbl[3] = '{n: 4, p: '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},    e_acc: 64'h3FFFC,   e_cnt: 64'd4, e_ovf: 1'b0};

    cycle();
    cycle();
    rst = 1'b0;
    chk("reset acc_out", 64'(acc0), 64'd0);
    chk("reset in_ready", 64'(rdy[0]), 64'd1);

    // Table vectors on the default instance; out_ready held high.
    for (int v = 0; v < 4; v++) begin
      out_ready = 1'b1;
      for (int i = 0; i < tbl[v].n; i++) beat(tbl[v].p[i], i == tbl[v].n - 1);
      chk($sformatf("tbl%0d out_valid", v),  64'(vld[0]), 64'd1);
      chk($sformatf("tbl%0d acc_out", v),    64'(acc0),   tbl[v].e_acc);
      chk($sformatf("tbl%0d beat_count", v), 64'(cnt0),   tbl[v].e_cnt);
      chk($sformatf("tbl%0d overflow", v),   64'(ovf[0]), 64'(tbl[v].e_ovf));
      drain();
      chk($sformatf("tbl%0d ready after", v), 64'(rdy[0]), 64'd1);
    end

    // Overflow with no guard bits, then backpressure with changing input.
    out_ready = 1'b0;
    beat(16'hFFFF, 1'b0);
    beat(16'h0002, 1'b1);
    chk("ovf acc_out", 64'(acc1), 64'h0001);
    chk("ovf overflow", 64'(ovf[1]), 64'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; product = 16'($urandom); in_last = 1'($urandom);
      cycle();
      chk("bp in_ready", 64'(rdy[1]), 64'd0);
      chk("bp acc_out held", 64'(acc1), 64'h0001);
    end
    in_last = 1'b0;
    drain();
    chk("drain overflow", 64'(ovf[1]), 64'd0);
    chk("drain acc_out", 64'(acc1), 64'd0);
    chk("drain in_ready", 64'(rdy[1]), 64'd1);

    // Beat-count saturation on the 2-bit counter.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) beat(16'd1, i == 4);
    chk("sat beat_count", 64'(cnt2), 64'd3);
    chk("sat acc_out", 64'(acc2), 64'd5);
    chk("nosat beat_count", 64'(cnt0), 64'd5);
    drain();

    // Reset mid-sequence discards the partial sum and a same-cycle handshake.
    beat(16'd3, 1'b0);
    beat(16'd4, 1'b0);
    rst = 1'b1;
    beat(16'd9, 1'b1);
    rst = 1'b0;
    beat(16'd7, 1'b1);
    chk("rst acc_out", 64'(acc0), 64'd7);
    chk("rst beat_count", 64'(cnt0), 64'd1);
    chk("rst out_valid", 64'(vld[0]), 64'd1);
    drain();

    // Randomised traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = 1'($urandom);
      product   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
